// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the Booth multiplier
// BOOTH_RADIX4_EN selects radix-4 recoding (bit triples, 2-bit shift); default is radix-2.
package mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

`ifdef BOOTH_RADIX4_EN
  localparam int RECODE_BITS = 3;
  localparam int SHIFT_BITS  = 2;
`else
  localparam int RECODE_BITS = 2;
  localparam int SHIFT_BITS  = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  typedef enum logic [2:0] {
    NOP,
    ADD1,
    SUB1,
    ADD2,
    SUB2
  } booth_op_t;

endpackage

// File: rtl/booth_encoder.sv
// rtl/booth_encoder.sv - Booth recoder: low multiplier bits plus Q(-1) to an add/sub operation
// BOOTH_RADIX4_EN selects the radix-4 table over {q1,q0,q-1}; otherwise radix-2 over {q0,q-1}.
module booth_encoder
  import mul_pkg::*;
(
  input  logic [RECODE_BITS-1:0] bits,
  output booth_op_t              op
);

  always_comb begin
    op = NOP;
`ifdef BOOTH_RADIX4_EN
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = NOP;
    endcase
`else
    case (bits)
      2'b01:   op = ADD1;
      2'b10:   op = SUB1;
      default: op = NOP;
    endcase
`endif
  end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed Booth multiplier (IDLE/RUN/FIN FSM, WIDTH+2 accumulator)
// BOOTH_RADIX4_EN selects radix-4 (WIDTH/2 steps); default radix-2 (WIDTH steps).
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / SHIFT_BITS;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  booth_op_t              op;
  logic [RECODE_BITS-1:0] recode_bits;
  logic [AW-1:0]          m_ext, m2_ext, sum;
  logic signed [AW+WIDTH:0] step_full, step_shr;

`ifdef BOOTH_RADIX4_EN
  assign recode_bits = {q_q[1:0], qm1_q};
`else
  assign recode_bits = {q_q[0], qm1_q};
`endif

  booth_encoder u_encoder (
    .bits (recode_bits),
    .op   (op)
  );

  assign m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
  assign m2_ext = {m_q[WIDTH-1], m_q, 1'b0};

  // One Booth step: add/sub into the accumulator, then shift {acc,Q,Q(-1)} arithmetically.
  always_comb begin
    sum = acc_q;
    case (op)
      ADD1:    sum = acc_q + m_ext;
      SUB1:    sum = acc_q - m_ext;
      ADD2:    sum = acc_q + m2_ext;
      SUB2:    sum = acc_q - m2_ext;
      default: sum = acc_q;
    endcase
    step_full = {sum, q_q, qm1_q};
    step_shr  = step_full >>> SHIFT_BITS;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_shr[AW+WIDTH:WIDTH+1];
        q_d   = step_shr[WIDTH:1];
        qm1_d = step_shr[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // The accumulator is sign-extended, so its low WIDTH bits are the true upper half.
        hi_d    = acc_q[WIDTH-1:0];
        lo_d    = q_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - directed self-checking bench for booth_multiplier
// BOOTH_RADIX4_EN changes only the expected latency (WIDTH/2 steps instead of WIDTH).
module tb_booth_multiplier;

  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int N = W / 2;
`else
  localparam int N = W;
`endif
  localparam int LAT = N + 2;

  logic         clock;
  logic         clear;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int lat;
  int dones;

  booth_multiplier #(.WIDTH(W)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Counts cycles from the start cycle until done is seen, bounded.
  task automatic wait_done(input int from, output int cycles);
    cycles = from;
    while (done !== 1'b1 && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                     input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int l;
    issue(m, q);
    check({tag, "_busy_run"}, W'(busy), W'(1));
    repeat (3) tick();
    check({tag, "_hold_hi"}, hi, prev_hi);
    check({tag, "_hold_lo"}, lo, prev_lo);
    wait_done(4, l);
    check({tag, "_latency"}, W'(l), W'(LAT));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy_idle"}, W'(busy), W'(0));
    tick();
    check({tag, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    clear        = 1'b1;
    start        = 1'b1;
    multiplicand = 32'd7;
    multiplier   = 32'd6;
    #12;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    tick();
    tick();
    check("rst_start_ignored", W'(busy), W'(0));
    start = 1'b0;
    clear = 1'b0;
    tick();

    run("m7x6", 32'd7, 32'd6, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_002A);
    run("mneg3x5", 32'hFFFF_FFFD, 32'd5, 32'h0000_0000, 32'h0000_002A,
        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF1,
        32'h4000_0000, 32'h0000_0000);
    run("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
        32'hC000_0000, 32'h8000_0000);
    run("neg1_x_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hC000_0000, 32'h8000_0000,
        32'h0000_0000, 32'h0000_0001);

    // start during RUN plus operand changes must not disturb the operation
    issue(32'd100, 32'hFFFF_FFF9);
    repeat (4) tick();
    multiplicand = 32'd2;
    multiplier   = 32'd2;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    wait_done(6, lat);
    check("ign_latency", W'(lat), W'(LAT));
    check("ign_hi", hi, 32'hFFFF_FFFF);
    check("ign_lo", lo, 32'hFFFF_FD44);
    count_dones(N + 6, dones);
    check("ign_single_done", W'(dones), W'(0));

    // asynchronous clear mid-operation
    issue(32'd5, 32'd9);
    repeat (9) tick();
    #2;
    clear = 1'b1;
    #1;
    check("clr_busy", W'(busy), W'(0));
    check("clr_done", W'(done), W'(0));
    check("clr_hi", hi, 32'h0);
    check("clr_lo", lo, 32'h0);
    tick();
    clear = 1'b0;
    count_dones(N + 6, dones);
    check("clr_no_done", W'(dones), W'(0));
    run("clr_new", 32'd4, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);

    // back-to-back: start presented on the done cycle
    issue(32'd3, 32'hFFFF_FFFE);
    wait_done(1, lat);
    check("b2b1_latency", W'(lat), W'(LAT));
    check("b2b1_hi", hi, 32'hFFFF_FFFF);
    check("b2b1_lo", lo, 32'hFFFF_FFFA);
    multiplicand = 32'h0001_0000;
    multiplier   = 32'h0001_0000;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    check("b2b2_busy", W'(busy), W'(1));
    check("b2b2_done_low", W'(done), W'(0));
    wait_done(1, lat);
    check("b2b2_latency", W'(lat), W'(LAT));
    check("b2b2_hi", hi, 32'h0000_0001);
    check("b2b2_lo", lo, 32'h0000_0000);
    tick();
    check("b2b2_done_pulse", W'(done), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
